// File: rtl/sys_defs.sv
// Shared bus command and tag definitions for the processor memory interface.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_RSVD  = 2'd3
  } bus_cmd_t;

  typedef logic [3:0] mem_tag_t;

  // Tags run 1..num_tags and wrap back to 1; 0 means "no tag".
  function automatic mem_tag_t next_tag(input mem_tag_t cur, input int num_tags);
    mem_tag_t nxt;
    if (cur >= 4'(num_tags)) begin
      nxt = 4'd1;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth completion pipeline carrying {valid, tag, is_load, idx} for each
// accepted memory transaction; cleared asynchronously when rst_n is low.
module mem_resp_pipe
  import sys_defs::*;
#(
  parameter int LATENCY = 1,
  parameter int IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  mem_tag_t         i_tag,
  input  logic             i_is_load,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output mem_tag_t         o_tag,
  output logic             o_is_load,
  output logic [IDX_W-1:0] o_idx
);

  logic             r_valid   [LATENCY];
  mem_tag_t         r_tag     [LATENCY];
  logic             r_is_load [LATENCY];
  logic [IDX_W-1:0] r_idx     [LATENCY];

  // Shift every stage one step toward the exit each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_valid[i]   <= 1'b0;
        r_tag[i]     <= 4'd0;
        r_is_load[i] <= 1'b0;
        r_idx[i]     <= '0;
      end
    end else begin
      r_valid[0]   <= i_valid;
      r_tag[0]     <= i_tag;
      r_is_load[0] <= i_is_load;
      r_idx[0]     <= i_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i]   <= r_valid[i-1];
        r_tag[i]     <= r_tag[i-1];
        r_is_load[i] <= r_is_load[i-1];
        r_idx[i]     <= r_idx[i-1];
      end
    end
  end

  assign o_valid   = r_valid[LATENCY-1];
  assign o_tag     = r_tag[LATENCY-1];
  assign o_is_load = r_is_load[LATENCY-1];
  assign o_idx     = r_idx[LATENCY-1];

endmodule

// File: rtl/unified_mem.sv
// Word-addressed single-port memory shared by instruction and data paths.
// Requests are tagged on accept; completions echo the tag after LATENCY cycles.
module unified_mem
  import sys_defs::*;
#(
  parameter int MEM_WORDS = 65536,
  parameter int LATENCY   = 0,
  parameter int NUM_TAGS  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  output mem_tag_t    mem2proc_response,
  output logic [31:0] mem2proc_data,
  output mem_tag_t    mem2proc_tag
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] unified_memory [MEM_WORDS];

  logic [29:0]      w_word;
  logic [IDX_W-1:0] w_idx;
  bus_cmd_t         w_cmd;
  logic             w_in_range;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_accept;
  mem_tag_t         r_tag;
  logic             w_unused;

  assign w_word     = proc2mem_addr[31:2];
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_in_range = ({2'b00, w_word} < 32'(MEM_WORDS));
  assign w_cmd      = bus_cmd_t'(proc2mem_command);
  assign w_is_load  = (w_cmd == BUS_LOAD) && w_in_range;
  assign w_is_store = (w_cmd == BUS_STORE) && w_in_range;
  // Nothing is accepted while held in reset, so no tag or store escapes it.
  assign w_accept   = rst && (w_is_load || w_is_store);
  assign w_unused   = ^proc2mem_addr[1:0];

  assign mem2proc_response = w_accept ? r_tag : 4'd0;

  // Tag issued to the next accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag <= 4'd1;
    end else if (w_accept) begin
      r_tag <= next_tag(r_tag, NUM_TAGS);
    end
  end

  // Store commit; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_store) begin
      unified_memory[w_idx] <= proc2mem_data;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign mem2proc_tag  = mem2proc_response;
      assign mem2proc_data = w_is_load ? unified_memory[w_idx] : 32'd0;
    end else begin : g_pipe
      logic             w_pipe_valid;
      mem_tag_t         w_pipe_tag;
      logic             w_pipe_is_load;
      logic [IDX_W-1:0] w_pipe_idx;

      mem_resp_pipe #(
        .LATENCY (LATENCY),
        .IDX_W   (IDX_W)
      ) u_pipe (
        .clk       (clk),
        .rst_n     (rst),
        .i_valid   (w_accept),
        .i_tag     (r_tag),
        .i_is_load (w_is_load),
        .i_idx     (w_idx),
        .o_valid   (w_pipe_valid),
        .o_tag     (w_pipe_tag),
        .o_is_load (w_pipe_is_load),
        .o_idx     (w_pipe_idx)
      );

      // Read at exit sees the array before any store committing this same edge.
      assign mem2proc_tag  = w_pipe_valid ? w_pipe_tag : 4'd0;
      assign mem2proc_data = (w_pipe_valid && w_pipe_is_load) ? unified_memory[w_pipe_idx] : 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_unified_mem.sv
// Bench for unified_mem: a combinational instance checked in-cycle and a
// LATENCY=4 instance checked through a completion scoreboard.
module tb_unified_mem;
  import sys_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst4;
  logic [31:0] a0, d0, a4, d4;
  logic [1:0]  c0, c4;
  mem_tag_t    resp0, tag0, resp4, tag4;
  logic [31:0] q0, q4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  mem_tag_t nt4 = 4'd1;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  unified_mem #(.MEM_WORDS(65536), .LATENCY(0), .NUM_TAGS(15)) u_mem0 (
    .clk(clk), .rst(rst0), .proc2mem_addr(a0), .proc2mem_data(d0),
    .proc2mem_command(c0), .mem2proc_response(resp0), .mem2proc_data(q0),
    .mem2proc_tag(tag0)
  );

  unified_mem #(.MEM_WORDS(65536), .LATENCY(4), .NUM_TAGS(15)) u_mem4 (
    .clk(clk), .rst(rst4), .proc2mem_addr(a4), .proc2mem_data(d4),
    .proc2mem_command(c4), .mem2proc_response(resp4), .mem2proc_data(q4),
    .mem2proc_tag(tag4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Completion monitor for the pipelined instance.
  always @(negedge clk) begin
    #2;
    if (tag4 != 4'd0) begin
      if (sb.size() == 0) begin
        check_eq("l4_unexpected_tag", 32'(tag4), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("l4_tag", 32'(tag4), 32'(e.tag));
        check_eq("l4_data", q4, e.data);
        check_eq("l4_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic drv0(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] exp_resp, input logic [31:0] exp_data, input string name);
    @(negedge clk);
    c0 = cmd; a0 = addr; d0 = wd;
    #1;
    check_eq({name, "_resp"}, 32'(resp0), 32'(exp_resp));
    check_eq({name, "_tag"}, 32'(tag0), 32'(exp_resp));
    check_eq({name, "_data"}, q0, exp_data);
  endtask

  task automatic drv4(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_data, input bit track);
    @(negedge clk);
    c4 = cmd; a4 = addr; d4 = wd;
    #1;
    check_eq("l4_resp", 32'(resp4), 32'(nt4));
    if (track) sb.push_back('{nt4, exp_data, cyc + 4});
    nt4 = (nt4 == 4'd15) ? 4'd1 : nt4 + 4'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c0 = BUS_NONE; c4 = BUS_NONE;
    end
  endtask

  task automatic pulse_rst0();
    @(negedge clk);
    c0 = BUS_NONE; rst0 = 1'b0;
    #1;
    check_eq("rst0_resp", 32'(resp0), 32'd0);
    @(negedge clk);
    rst0 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0; rst4 = 1'b0;
    c0 = BUS_NONE; c4 = BUS_NONE;
    a0 = 32'd0; d0 = 32'd0; a4 = 32'd0; d4 = 32'd0;
    u_mem0.unified_memory[3] = 32'hDEADBEEF;
    u_mem4.unified_memory[0] = 32'hCAFE0000;
    u_mem4.unified_memory[5] = 32'h55550005;
    u_mem4.unified_memory[6] = 32'h00000000;
    #12;
    check_eq("rst_resp0", 32'(resp0), 32'd0);
    check_eq("rst_tag0", 32'(tag0), 32'd0);
    check_eq("rst_data0", q0, 32'd0);
    check_eq("rst_resp4", 32'(resp4), 32'd0);
    check_eq("rst_tag4", 32'(tag4), 32'd0);
    check_eq("rst_data4", q4, 32'd0);

    @(negedge clk);
    rst0 = 1'b1; rst4 = 1'b1;
    #1;
    check_eq("idle_resp0", 32'(resp0), 32'd0);
    check_eq("idle_tag0", 32'(tag0), 32'd0);
    check_eq("idle_data0", q0, 32'd0);

    // Combinational instance
    drv0(BUS_LOAD, 32'h0000_000C, 32'd0, 4'd1, 32'hDEADBEEF, "ld_preload");
    pulse_rst0();
    drv0(BUS_STORE, 32'h0000_0010, 32'h12345678, 4'd1, 32'd0, "st");
    drv0(BUS_LOAD, 32'h0000_0010, 32'd0, 4'd2, 32'h12345678, "ld_after_st");
    pulse_rst0();
    for (int i = 0; i < 16; i++) begin
      drv0(BUS_LOAD, 32'h0000_0010, 32'd0, 4'((i % 15) + 1), 32'h12345678, "wrap");
    end
    drv0(BUS_LOAD, 32'h0004_0000, 32'd0, 4'd0, 32'd0, "oor_ld");
    drv0(BUS_STORE, 32'h0004_0010, 32'hBAD0BAD0, 4'd0, 32'd0, "oor_st");
    drv0(2'd3, 32'h0000_0010, 32'd0, 4'd0, 32'd0, "cmd3");
    drv0(BUS_LOAD, 32'h0000_0010, 32'd0, 4'd2, 32'h12345678, "ld_post_oor");
    drv0(BUS_LOAD, 32'h0000_000C, 32'd0, 4'd3, 32'hDEADBEEF, "ld_word3");
    idle(1);

    // Pipelined instance
    drv4(BUS_LOAD, 32'h0000_0000, 32'd0, 32'hCAFE0000, 1'b1);
    idle(5);
    drv4(BUS_STORE, 32'h0000_0018, 32'h66666666, 32'd0, 1'b1);
    drv4(BUS_LOAD, 32'h0000_0018, 32'd0, 32'h66666666, 1'b1);
    drv4(BUS_LOAD, 32'h0000_0014, 32'd0, 32'h55550005, 1'b1);
    idle(6);
    drv4(BUS_LOAD, 32'h0000_0014, 32'd0, 32'h55550005, 1'b1);
    idle(3);
    drv4(BUS_STORE, 32'h0000_0014, 32'h77770005, 32'd0, 1'b1);
    drv4(BUS_LOAD, 32'h0000_0014, 32'd0, 32'h77770005, 1'b1);
    idle(6);

    // Reset while a load is in flight: it must never complete
    drv4(BUS_LOAD, 32'h0000_0000, 32'd0, 32'd0, 1'b0);
    idle(1);
    @(negedge clk);
    c4 = BUS_NONE; rst4 = 1'b0;
    #1;
    check_eq("l4_rst_resp", 32'(resp4), 32'd0);
    check_eq("l4_rst_data", q4, 32'd0);
    idle(2);
    @(negedge clk);
    rst4 = 1'b1; nt4 = 4'd1;
    idle(6);
    drv4(BUS_LOAD, 32'h0000_0000, 32'd0, 32'hCAFE0000, 1'b1);
    idle(6);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
